pslip_round_ctrl: RTL and testbench

Sequencing controller for the pSLIP priority scheduler: one scheduling round per time slot. It snapshots the VOQ head priorities, launches the scheduler, and counts its per-iteration ready strobes up to a fixed iteration budget. It then publishes the final match matrix to the crossbar through a valid/ready handshake. It sits between the VOQ bank, `pri_scheduler` and the crossbar configuration register.

---
 rtl/pslip_round_ctrl.sv | 148 ++++++++++++++
 tb/tb_pslip_round_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pslip_round_ctrl.sv
// pslip_round_ctrl: per-slot round sequencer for the pSLIP priority scheduler.
// Snapshots VOQ head priorities, launches the scheduler, counts iteration strobes
// under a watchdog, then publishes the match matrix to the crossbar by valid/ready.
// Optional build macro: PSLIP_EARLY_TERM_EN ends a round early once two consecutive
// strobes carry the same decision (scheduler convergence).
module pslip_round_ctrl #(
    parameter int unsigned N       = 4,
    parameter int unsigned P       = 16,
    parameter int unsigned C       = $clog2(P),
    parameter int unsigned ITER    = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             slot_start,
    input  logic [C-1:0][0:N-1][0:N-1]       voq_pri,
    input  logic                             err_clr,
    output logic                             sched_start,
    output logic [C-1:0][0:N-1][0:N-1]       sched_req,
    input  logic                             sched_ready,
    input  logic [N-1:0][N-1:0]              sched_decision,
    output logic [N-1:0][N-1:0]              xbar_cfg,
    output logic                             xbar_valid,
    input  logic                             xbar_ready,
    output logic                             busy,
    output logic [$clog2(ITER+1)-1:0]        iter_cnt,
    output logic                             overrun_err,
    output logic                             timeout_err
);

    localparam int unsigned IW = $clog2(ITER + 1);
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StLaunch, StIter, StPublish} state_e;

    state_e        state_q;
    logic [WW-1:0] wdog_q;
    logic [IW-1:0] iter_next;
    logic          iter_done;
    logic          dec_legal;

`ifdef PSLIP_EARLY_TERM_EN
    logic [N-1:0][N-1:0] prev_q;
    logic                converged;
`endif

    // A legal match has at most one bit per row (input) and per column (output).
    function automatic logic match_legal(input logic [N-1:0][N-1:0] d);
        logic         ok;
        logic [N-1:0] col;
        ok = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (!$onehot0(d[i])) ok = 1'b0;
        end
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < N; i++) col[i] = d[i][j];
            if (!$onehot0(col)) ok = 1'b0;
        end
        return ok;
    endfunction

    // Strobe bookkeeping: saturating next count, round-complete and legality decode.
    always_comb begin
        iter_next = (iter_cnt == IW'(ITER)) ? iter_cnt : iter_cnt + 1'b1;
        iter_done = (iter_next == IW'(ITER));
        dec_legal = match_legal(sched_decision);
`ifdef PSLIP_EARLY_TERM_EN
        // Needs a previous strobe from this round, hence iter_cnt != 0.
        converged = (iter_cnt != '0) && (sched_decision == prev_q);
        iter_done = iter_done | converged;
`endif
    end

    // Round FSM with registered outputs and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            wdog_q      <= '0;
            sched_start <= 1'b0;
            sched_req   <= '0;
            xbar_cfg    <= '0;
            xbar_valid  <= 1'b0;
            busy        <= 1'b0;
            iter_cnt    <= '0;
            overrun_err <= 1'b0;
            timeout_err <= 1'b0;
`ifdef PSLIP_EARLY_TERM_EN
            prev_q      <= '0;
`endif
        end else begin
            sched_start <= 1'b0;
            // Clear first so a same-cycle set below takes precedence.
            if (err_clr) begin
                overrun_err <= 1'b0;
                timeout_err <= 1'b0;
            end
            if (slot_start && (state_q != StIdle)) overrun_err <= 1'b1;

            unique case (state_q)
                StIdle: begin
                    if (slot_start) begin
                        sched_req   <= voq_pri;
                        iter_cnt    <= '0;
                        wdog_q      <= '0;
                        sched_start <= 1'b1;
                        busy        <= 1'b1;
                        state_q     <= StLaunch;
                    end
                end
                StLaunch: begin
                    state_q <= StIter;
                end
                StIter: begin
                    if (sched_ready) begin
                        iter_cnt <= iter_next;
                        wdog_q   <= '0;
`ifdef PSLIP_EARLY_TERM_EN
                        prev_q   <= sched_decision;
`endif
                        if (iter_done) begin
                            // An illegal match is a scheduler fault: publish nothing.
                            xbar_cfg   <= dec_legal ? sched_decision : '0;
                            xbar_valid <= 1'b1;
                            state_q    <= StPublish;
                            if (!dec_legal) timeout_err <= 1'b1;
                        end
                    end else if (wdog_q == WW'(TIMEOUT - 1)) begin
                        xbar_cfg    <= '0;
                        xbar_valid  <= 1'b1;
                        timeout_err <= 1'b1;
                        state_q     <= StPublish;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                StPublish: begin
                    if (xbar_ready) begin
                        xbar_valid <= 1'b0;
                        busy       <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pslip_round_ctrl.sv
// Self-checking bench for pslip_round_ctrl: directed scenarios plus randomized
// rounds checked against a round-level reference model.
module tb_pslip_round_ctrl;

    localparam int N       = 4;
    localparam int P       = 16;
    localparam int C       = 4;
    localparam int ITER    = 4;
    localparam int TIMEOUT = 64;

    typedef logic [N-1:0][N-1:0]       mat_t;
    typedef logic [C-1:0][0:N-1][0:N-1] pri_t;

    logic clk         = 1'b0;
    logic reset       = 1'b0;
    logic slot_start  = 1'b0;
    logic err_clr     = 1'b0;
    logic sched_ready = 1'b0;
    logic xbar_ready  = 1'b0;
    pri_t voq_pri     = '0;
    mat_t sched_decision = '0;

    logic       sched_start;
    pri_t       sched_req;
    mat_t       xbar_cfg;
    logic       xbar_valid;
    logic       busy;
    logic [2:0] iter_cnt;
    logic       overrun_err;
    logic       timeout_err;

    int   n_tests = 0;
    int   n_fail  = 0;
    mat_t dec_seq [ITER];

    pslip_round_ctrl #(
        .N       (N),
        .P       (P),
        .C       (C),
        .ITER    (ITER),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .slot_start     (slot_start),
        .voq_pri        (voq_pri),
        .err_clr        (err_clr),
        .sched_start    (sched_start),
        .sched_req      (sched_req),
        .sched_ready    (sched_ready),
        .sched_decision (sched_decision),
        .xbar_cfg       (xbar_cfg),
        .xbar_valid     (xbar_valid),
        .xbar_ready     (xbar_ready),
        .busy           (busy),
        .iter_cnt       (iter_cnt),
        .overrun_err    (overrun_err),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: at most one grant per input row and per output column.
    function automatic bit legal_m(input mat_t m);
        int r;
        int c;
        for (int i = 0; i < N; i++) begin
            r = 0;
            c = 0;
            for (int j = 0; j < N; j++) begin
                r += int'(m[i][j]);
                c += int'(m[j][i]);
            end
            if (r > 1 || c > 1) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Reference: number of strobes a round takes for the decisions in dec_seq.
    function automatic int exp_strobes();
`ifdef PSLIP_EARLY_TERM_EN
        for (int k = 1; k < ITER; k++) begin
            if (dec_seq[k] == dec_seq[k-1]) return k + 1;
        end
`endif
        return ITER;
    endfunction

    function automatic mat_t shift_perm(input int s);
        mat_t m;
        m = '0;
        for (int i = 0; i < N; i++) m[i][(i + s) % N] = 1'b1;
        return m;
    endfunction

    function automatic mat_t rand_perm();
        int   p [N];
        int   t;
        int   r;
        mat_t m;
        for (int i = 0; i < N; i++) p[i] = i;
        for (int i = N - 1; i > 0; i--) begin
            r    = int'($urandom_range(i, 0));
            t    = p[i];
            p[i] = p[r];
            p[r] = t;
        end
        m = '0;
        for (int i = 0; i < N; i++) m[i][p[i]] = 1'b1;
        return m;
    endfunction

    function automatic pri_t diag_pri(input int v);
        pri_t     q;
        bit [3:0] vb;
        q  = '0;
        vb = 4'(v);
        for (int i = 0; i < N; i++) begin
            for (int c = 0; c < C; c++) q[c][i][i] = vb[c];
        end
        return q;
    endfunction

    task automatic clr_err();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    // One full round driven from dec_seq; expectations come from the model above.
    task automatic run_round(input pri_t pri, input int max_gap, input int bp_cycles,
                             input bit probe_overrun, input bit slot_at_hs);
        int   ns;
        mat_t exp_cfg;
        bit   ok;
        ns      = exp_strobes();
        ok      = legal_m(dec_seq[ns-1]);
        exp_cfg = ok ? dec_seq[ns-1] : '0;

        voq_pri    = pri;
        slot_start = 1'b1;
        tick();
        slot_start = 1'b0;
        voq_pri    = pri_t'({$urandom, $urandom});
        check("launch sched_start", sched_start, 1);
        check("launch busy", busy, 1);
        check("launch sched_req", sched_req, pri);
        check("launch iter_cnt", iter_cnt, 0);
        tick();
        check("iter sched_start low", sched_start, 0);

        if (probe_overrun) begin
            slot_start = 1'b1;
            tick();
            slot_start = 1'b0;
            check("overrun flag", overrun_err, 1);
            check("overrun sched_req kept", sched_req, pri);
            check("overrun busy", busy, 1);
            check("overrun no relaunch", sched_start, 0);
            err_clr    = 1'b1;
            slot_start = 1'b1;
            tick();
            slot_start = 1'b0;
            check("overrun set wins", overrun_err, 1);
            tick();
            err_clr = 1'b0;
            check("overrun cleared", overrun_err, 0);
        end

        for (int k = 0; k < ns; k++) begin
            repeat ($urandom_range(max_gap, 0)) begin
                sched_decision = mat_t'($urandom);
                tick();
            end
            sched_ready    = 1'b1;
            sched_decision = dec_seq[k];
            tick();
            sched_ready    = 1'b0;
            sched_decision = mat_t'($urandom);
            check("strobe iter_cnt", iter_cnt, k + 1);
            check("strobe xbar_valid", xbar_valid, (k == ns - 1) ? 1 : 0);
        end
        check("publish xbar_cfg", xbar_cfg, exp_cfg);
        check("publish timeout_err", timeout_err, ok ? 0 : 1);
        check("publish sched_req held", sched_req, pri);

        for (int b = 0; b < bp_cycles; b++) begin
            tick();
            check("bp xbar_valid", xbar_valid, 1);
            check("bp xbar_cfg", xbar_cfg, exp_cfg);
            check("bp busy", busy, 1);
        end

        xbar_ready = 1'b1;
        if (slot_at_hs) slot_start = 1'b1;
        tick();
        xbar_ready = 1'b0;
        slot_start = 1'b0;
        check("hs xbar_valid", xbar_valid, 0);
        check("hs busy", busy, 0);
        if (slot_at_hs) begin
            check("hs slot overrun", overrun_err, 1);
            check("hs slot not launched", sched_start, 0);
        end
    endtask

    initial begin
        int   n;
        mat_t ill;

        // Reset values.
        repeat (3) tick();
        check("rst sched_start", sched_start, 0);
        check("rst sched_req", sched_req, 0);
        check("rst xbar_cfg", xbar_cfg, 0);
        check("rst xbar_valid", xbar_valid, 0);
        check("rst busy", busy, 0);
        check("rst iter_cnt", iter_cnt, 0);
        check("rst overrun_err", overrun_err, 0);
        check("rst timeout_err", timeout_err, 0);
        reset = 1'b1;
        tick();

        // Basic round ending on identity, then 10 cycles of backpressure.
        dec_seq[0] = shift_perm(1);
        dec_seq[1] = shift_perm(2);
        dec_seq[2] = shift_perm(3);
        dec_seq[3] = shift_perm(0);
        run_round(diag_pri(5), 0, 10, 1'b0, 1'b0);
        check("basic identity", xbar_cfg, shift_perm(0));

        // Overrun while in ITER, and slot_start coinciding with the handshake.
        dec_seq[0] = shift_perm(2);
        dec_seq[1] = shift_perm(1);
        dec_seq[2] = shift_perm(3);
        dec_seq[3] = shift_perm(2);
        run_round(pri_t'({$urandom, $urandom}), 1, 0, 1'b1, 1'b1);
        clr_err();
        check("overrun clr", overrun_err, 0);

        // Illegal match on the final strobe.
        ill        = '0;
        ill[0]     = 4'b0011;
        dec_seq[0] = shift_perm(1);
        dec_seq[1] = shift_perm(2);
        dec_seq[2] = shift_perm(3);
        dec_seq[3] = ill;
        run_round(pri_t'({$urandom, $urandom}), 2, 2, 1'b0, 1'b0);
        check("illegal cfg zero", xbar_cfg, 0);
        clr_err();
        check("illegal err clr", timeout_err, 0);

        // Watchdog expiry with no strobes.
        voq_pri    = pri_t'({$urandom, $urandom});
        slot_start = 1'b1;
        tick();
        slot_start = 1'b0;
        tick();
        n = 0;
        while (!xbar_valid && n < 200) begin
            tick();
            n++;
        end
        check("timeout latency", (n >= TIMEOUT - 2 && n <= TIMEOUT + 1) ? 1 : 0, 1);
        check("timeout xbar_valid", xbar_valid, 1);
        check("timeout xbar_cfg", xbar_cfg, 0);
        check("timeout err", timeout_err, 1);
        sched_ready    = 1'b1;
        sched_decision = shift_perm(0);
        tick();
        sched_ready = 1'b0;
        check("publish ignores strobe cnt", iter_cnt, 0);
        check("publish ignores strobe cfg", xbar_cfg, 0);
        xbar_ready = 1'b1;
        tick();
        xbar_ready = 1'b0;
        check("timeout hs busy", busy, 0);
        clr_err();

        // Reset mid-round after two strobes.
        voq_pri    = pri_t'({$urandom, $urandom});
        slot_start = 1'b1;
        tick();
        slot_start = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            sched_ready    = 1'b1;
            sched_decision = shift_perm(k + 1);
            tick();
            sched_ready = 1'b0;
        end
        check("mid iter_cnt", iter_cnt, 2);
        reset = 1'b0;
        #1;
        check("async rst busy", busy, 0);
        check("async rst iter_cnt", iter_cnt, 0);
        check("async rst sched_req", sched_req, 0);
        check("async rst xbar_valid", xbar_valid, 0);
        check("async rst xbar_cfg", xbar_cfg, 0);
        check("async rst sched_start", sched_start, 0);
        tick();
        reset = 1'b1;
        tick();
        for (int k = 0; k < ITER; k++) dec_seq[k] = shift_perm(k % N);
        run_round(pri_t'({$urandom, $urandom}), 1, 1, 1'b0, 1'b0);

`ifdef PSLIP_EARLY_TERM_EN
        // Matching decisions on strobes 1 and 2 end the round early.
        dec_seq[0] = shift_perm(3);
        dec_seq[1] = shift_perm(3);
        dec_seq[2] = shift_perm(1);
        dec_seq[3] = shift_perm(2);
        run_round(pri_t'({$urandom, $urandom}), 0, 0, 1'b0, 1'b0);
        check("early iter_cnt", iter_cnt, 2);
        check("early cfg", xbar_cfg, shift_perm(3));
`endif

        // Randomized rounds.
        for (int r = 0; r < 25; r++) begin
            clr_err();
            for (int k = 0; k < ITER; k++) dec_seq[k] = rand_perm();
            if ($urandom_range(3, 0) == 0) dec_seq[ITER-1] = mat_t'($urandom);
            run_round(pri_t'({$urandom, $urandom}), 3, int'($urandom_range(5, 0)),
                      1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
